// File: rtl/flappy_game_render.sv
// ============================================================================
//  Module   : flappy_game_render
//  Purpose  : Pixel-stage game logic for a one-button "flappy" game. Holds
//             bird physics, one scrolling pipe pair, score and an
//             IDLE/PLAY/DEAD state machine (all advanced once per frame),
//             and produces registered 8-bit RGB for the VGA DAC.
//  Ports    : clk           - pixel clock (shared with the sync generator)
//             reset         - synchronous, active-low
//             CounterX/Y    - current column / line from the sync generator
//             inDisplayArea - visible flag, lags the counters by one cycle
//             btn_flap      - flap button level (synchronised, debounced)
//             vga_r/g/b     - 3/3/2-bit colour, zero outside visible area
//             score         - pipes passed, saturating at 255
//             game_over     - high while in DEAD
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module flappy_game_render #(
    parameter int BIRD_X     = 160,
    parameter int BIRD_SIZE  = 16,
    parameter int PIPE_W     = 48,
    parameter int GAP_H      = 120,
    parameter int GRAVITY    = 1,
    parameter int MAX_FALL   = 12,
    parameter int FLAP_VEL   = 10,
    parameter int PIPE_SPEED = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] CounterX,
    input  logic [9:0] CounterY,
    input  logic       inDisplayArea,
    input  logic       btn_flap,
    output logic [2:0] vga_r,
    output logic [2:0] vga_g,
    output logic [1:0] vga_b,
    output logic [7:0] score,
    output logic       game_over
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_DEAD = 2'd2
    } state_t;

    localparam logic [9:0]        c_BIRD_Y0  = 10'd232;
    localparam logic [9:0]        c_PIPE_X0  = 10'd640;
    localparam logic [9:0]        c_GAP_Y0   = 10'd200;
    localparam logic [9:0]        c_FLOOR    = 10'(480 - BIRD_SIZE);
    localparam logic signed [5:0] c_VEL_FLAP = 6'(-FLAP_VEL);
    localparam logic signed [5:0] c_VEL_MAX  = 6'(MAX_FALL);
    localparam logic signed [5:0] c_VEL_GRAV = 6'(GRAVITY);

    // Colours packed as {r[2:0], g[2:0], b[1:0]}
    localparam logic [7:0] c_COL_BIRD = {3'd7, 3'd7, 2'd0};
    localparam logic [7:0] c_COL_PIPE = {3'd0, 3'd5, 2'd0};
    localparam logic [7:0] c_COL_SKY  = {3'd2, 3'd5, 2'd3};
    localparam logic [7:0] c_COL_DEAD = {3'd5, 3'd1, 2'd1};

    state_t            r_state;
    logic [9:0]        r_bird_y;
    logic signed [5:0] r_vel;
    logic [9:0]        r_pipe_x;
    logic [9:0]        r_gap_y;
    logic [7:0]        r_score;
    logic [7:0]        r_lfsr;
    logic              r_btn_prev;
    logic              r_flap_pend;
    logic              r_hit;
    logic [7:0]        r_rgb;

    logic [10:0]        w_x;
    logic [10:0]        w_y;
    logic               w_tick;
    logic               w_flap_edge;
    logic               w_lfsr_fb;
    logic               w_bird_px;
    logic               w_pipe_px;
    logic signed [5:0]  w_vel_grav;
    logic signed [5:0]  w_vel_next;
    logic signed [10:0] w_bird_next;
    logic               w_hit_ceiling;
    logic               w_hit_floor;
    logic               w_pipe_wrap;
    logic [7:0]         w_colour;

    // 11-bit views so that edge sums (pipe_x + PIPE_W etc.) never overflow
    assign w_x = {1'b0, CounterX};
    assign w_y = {1'b0, CounterY};

    assign w_tick      = (CounterY == 10'd480) && (CounterX == 10'd0);
    assign w_flap_edge = btn_flap & ~r_btn_prev;
    // Fibonacci LFSR for x^8 + x^6 + x^5 + x^4 + 1
    assign w_lfsr_fb   = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];

    assign w_bird_px = (w_x >= 11'(BIRD_X)) && (w_x < 11'(BIRD_X + BIRD_SIZE)) &&
                       (w_y >= {1'b0, r_bird_y}) &&
                       (w_y < ({1'b0, r_bird_y} + 11'(BIRD_SIZE)));

    // X < 640 clips a pipe that is still sliding in from the right edge
    assign w_pipe_px = (w_x >= {1'b0, r_pipe_x}) &&
                       (w_x < ({1'b0, r_pipe_x} + 11'(PIPE_W))) &&
                       (w_x < 11'd640) &&
                       ((w_y < {1'b0, r_gap_y}) ||
                        (w_y >= ({1'b0, r_gap_y} + 11'(GAP_H))));

    assign w_vel_grav = r_vel + c_VEL_GRAV;
    assign w_vel_next = r_flap_pend ? c_VEL_FLAP :
                        ((w_vel_grav > c_VEL_MAX) ? c_VEL_MAX : w_vel_grav);

    assign w_bird_next   = $signed({1'b0, r_bird_y}) + {{5{w_vel_next[5]}}, w_vel_next};
    assign w_hit_ceiling = w_bird_next[10];
    assign w_hit_floor   = !w_bird_next[10] && (w_bird_next[9:0] > c_FLOOR);
    assign w_pipe_wrap   = r_pipe_x < 10'(PIPE_SPEED);

    always_comb begin
        w_colour = (r_state == S_DEAD) ? c_COL_DEAD : c_COL_SKY;
        if (w_bird_px) begin
            w_colour = c_COL_BIRD;
        end else if (w_pipe_px) begin
            w_colour = c_COL_PIPE;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_bird_y    <= c_BIRD_Y0;
            r_vel       <= '0;
            r_pipe_x    <= c_PIPE_X0;
            r_gap_y     <= c_GAP_Y0;
            r_score     <= '0;
            r_lfsr      <= 8'hA5;
            r_btn_prev  <= 1'b0;
            r_flap_pend <= 1'b0;
            r_hit       <= 1'b0;
            r_rgb       <= '0;
        end else begin
            r_lfsr     <= {r_lfsr[6:0], w_lfsr_fb};
            r_btn_prev <= btn_flap;
            r_rgb      <= w_colour;

            // An edge arriving on the tick itself survives into the next frame
            r_flap_pend <= w_tick ? w_flap_edge : (r_flap_pend | w_flap_edge);
            // The tick samples r_hit before it is cleared here
            r_hit <= w_tick ? 1'b0 :
                     (r_hit | ((r_state == S_PLAY) && w_bird_px && w_pipe_px));

            if (w_tick) begin
                case (r_state)
                    S_IDLE: begin
                        // The launching tick already applies the flap impulse
                        if (r_flap_pend) begin
                            r_state  <= S_PLAY;
                            r_score  <= '0;
                            r_vel    <= c_VEL_FLAP;
                            r_bird_y <= c_BIRD_Y0 - 10'(FLAP_VEL);
                        end
                    end
                    S_PLAY: begin
                        r_vel <= w_vel_next;
                        if (w_hit_ceiling) begin
                            r_bird_y <= '0;
                        end else if (w_hit_floor) begin
                            r_bird_y <= c_FLOOR;
                        end else begin
                            r_bird_y <= w_bird_next[9:0];
                        end
                        if (w_pipe_wrap) begin
                            r_pipe_x <= c_PIPE_X0;
                            r_gap_y  <= 10'd64 + {2'b00, r_lfsr};
                            if (r_score != 8'hFF) begin
                                r_score <= r_score + 8'd1;
                            end
                        end else begin
                            r_pipe_x <= r_pipe_x - 10'(PIPE_SPEED);
                        end
                        if (w_hit_ceiling || w_hit_floor || r_hit) begin
                            r_state <= S_DEAD;
                        end
                    end
                    S_DEAD: begin
                        if (r_flap_pend) begin
                            r_state  <= S_IDLE;
                            r_bird_y <= c_BIRD_Y0;
                            r_vel    <= '0;
                            r_pipe_x <= c_PIPE_X0;
                            r_gap_y  <= c_GAP_Y0;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign {vga_r, vga_g, vga_b} = r_rgb & {8{inDisplayArea}};
    assign score     = r_score;
    assign game_over = (r_state == S_DEAD);

endmodule

`default_nettype wire

// File: doc/flappy_game_render.md
Name: flappy_game_render

Overview:
Pixel-stage consumer of the VGA sync generator's CounterX, CounterY and inDisplayArea outputs. It holds the game state: bird vertical physics, one scrolling pipe pair, score, and an IDLE/PLAY/DEAD state machine. All state updates once per frame. Per pixel it produces registered 8-bit RGB for the board VGA DAC.

Parameters:
BIRD_X, 160, left column of bird sprite
BIRD_SIZE, 16, bird square edge in pixels
PIPE_W, 48, pipe width in pixels
GAP_H, 120, vertical gap height in pixels
GRAVITY, 1, velocity increment per frame (px/frame)
MAX_FALL, 12, maximum downward velocity
FLAP_VEL, 10, upward velocity loaded on flap
PIPE_SPEED, 2, pipe leftward shift per frame

Ports:
clk  in  1  pixel clock, same clock as sync generator
reset  in  1  synchronous, active-low; state resets on the rising clk edge where reset==0
CounterX  in  10  current column, 0..800
CounterY  in  10  current line, 0..521
inDisplayArea  in  1  registered visible flag; lags counters by 1 cycle
btn_flap  in  1  flap button level, already synchronised and debounced
vga_r  out  3  red
vga_g  out  3  green
vga_b  out  2  blue
score  out  8  pipes passed, saturating
game_over  out  1  high in DEAD

Behaviour:
- Reset (reset==0): state=IDLE; bird_y=232; vel=0; pipe_x=640; gap_y=200; score=0; lfsr=8'hA5; flap_pend=0; hit=0; RGB=0; game_over=0.
- frame_tick: 1-cycle pulse when CounterY==480 && CounterX==0. Exactly one pulse per frame.
- Flap capture: a rising edge of btn_flap (registered previous level) sets flap_pend. frame_tick consumes and clears flap_pend. An edge on the same cycle as frame_tick stays pending for the next frame.
- LFSR: 8-bit, taps x^8+x^6+x^5+x^4+1. Advances every clock in every state except reset.
- FSM, evaluated only on frame_tick:
  - IDLE: bird_y held at 232, pipe static. flap_pend -> PLAY, score=0, vel=-FLAP_VEL.
  - PLAY, velocity: vel = flap_pend ? -FLAP_VEL : min(vel+GRAVITY, MAX_FALL). vel is signed 6-bit.
  - PLAY, bird position: next = bird_y + vel, 11-bit signed.
    - next<0: bird_y=0, go to DEAD.
    - next>480-BIRD_SIZE: bird_y=480-BIRD_SIZE, go to DEAD.
    - otherwise bird_y=next.
  - PLAY, pipe: if pipe_x<PIPE_SPEED then pipe_x=640, gap_y=64+lfsr, score=min(score+1,255); else pipe_x-=PIPE_SPEED.
  - PLAY, collision: hit==1 at the tick -> DEAD. Wall and hit deaths on the same tick give a single DEAD transition.
  - DEAD: everything frozen; game_over=1. flap_pend -> IDLE with bird_y=232, vel=0, pipe_x=640, gap_y=200. Score is held until the next IDLE->PLAY.
- hit flag: set on any cycle in PLAY where bird_px && pipe_px for the current counters. Cleared on frame_tick, after being sampled.
- Pixel classification, combinational on CounterX/Y:
  - bird_px: BIRD_X<=X<BIRD_X+BIRD_SIZE and bird_y<=Y<bird_y+BIRD_SIZE.
  - pipe_px: pipe_x<=X<pipe_x+PIPE_W, X<640, and (Y<gap_y or Y>=gap_y+GAP_H).
  - Pipe partially off-screen right (pipe_x>592) is clipped by X<640.
- Colour priority: bird {7,7,0} > pipe {0,5,0} > sky {2,5,3}. In DEAD, sky becomes {5,1,1}.
- Output timing: colour is registered (1-cycle latency), then ANDed with inDisplayArea. Both then refer to the same counter values. Blanked pixels drive RGB=0.
- Reset mid-frame: takes effect next clock, RGB=0 that cycle. No frame_tick is generated until CounterY next reaches 480.

Test Plan:
- Hold reset low 5 clk, release -> RGB=0, score=0, game_over=0, state IDLE. At pixel (160,232), one cycle later, RGB={7,7,0}.
- IDLE, no flap, 3 frames -> bird_y stays 232, pipe_x stays 640, no colour change at (300,100).
- Flap in IDLE -> PLAY on next tick with vel=-10, bird_y=222. Following ticks give vel -9,-8,…, capping at +12 when no flap.
- PLAY with no flaps from bird_y=232 -> floor hit: bird_y clamps to 464, game_over=1, sky at (10,10) = {5,1,1}. Flap -> IDLE, bird_y=232, score retained.
- Force pipe_x=1 in PLAY -> next tick pipe_x=640, score+1, gap_y=64+lfsr. With score=255 it stays 255.
- Bird overlapping pipe body (pipe_x=150, gap_y=400) -> hit set during draw; next frame_tick -> DEAD. Flap edge coincident with frame_tick -> consumed on the following tick.
